// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default widths, stage FSM states, requantization helper.
package cnn_pkg;

    localparam int unsigned ACC_WIDTH = 24;
    localparam int unsigned OFM_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Round half up, arithmetic right shift, then saturate to a signed ofm_w-bit range.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] s,
                                                     input int unsigned     shift,
                                                     input int unsigned     ofm_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (s + (64'sd1 <<< (shift - 32'd1))) >>> shift;
        hi = (64'sd1 <<< (ofm_w - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (ofm_w - 32'd1));
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction

endpackage

// File: rtl/psum_acc_ram.sv
// DEPTH x WIDTH register-file accumulator: asynchronous read, synchronous write, same cycle.
module psum_acc_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 24,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents need no reset: the first pass of every tile overwrites each entry.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/psum_acc_quant.sv
// PE-column partial-sum accumulator with bias, requantization and valid/ready output.
// Build option: define PSUM_ACC_QUANT_RELU_EN to clamp negative sums to zero before the shift.
module psum_acc_quant #(
    parameter int unsigned PSUM_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = cnn_pkg::ACC_WIDTH,
    parameter int unsigned OFM_WIDTH  = cnn_pkg::OFM_WIDTH,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NUM_PASS   = 4,
    parameter int unsigned SHIFT      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [ACC_WIDTH-1:0]  bias,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [PSUM_WIDTH-1:0] psum_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OFM_WIDTH-1:0]  ofm_out,
    output logic                         busy,
    output logic                         done
);

    import cnn_pkg::*;

    localparam int unsigned PIX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PASS_W = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;

    localparam logic [PIX_W-1:0]  PIX_LAST    = PIX_W'(DEPTH - 1);
    localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASS - 1);
    localparam logic [PASS_W-1:0] PASS_PENULT = PASS_W'((NUM_PASS > 1) ? NUM_PASS - 2 : 0);

    state_e state;
    state_e state_nx;

    logic [PIX_W-1:0]  pix_cnt;
    logic [PASS_W-1:0] pass_cnt;
    logic              in_beat;
    logic              out_hs;
    logic              acc_we;

    logic signed [ACC_WIDTH-1:0] acc_rd;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] acc_wr;
    logic signed [ACC_WIDTH-1:0] sum_s;
    logic signed [ACC_WIDTH-1:0] sum_q;
    logic signed [OFM_WIDTH-1:0] q_val;

    psum_acc_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ACC_WIDTH),
        .AW    (PIX_W)
    ) u_ram (
        .clk   (clk),
        .we    (acc_we),
        .waddr (pix_cnt),
        .wdata (acc_wr),
        .raddr (pix_cnt),
        .rdata (acc_rd)
    );

    assign in_beat = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (NUM_PASS > 1) ? ACCUM : FINAL;
            ACCUM: if (in_beat && pix_cnt == PIX_LAST && pass_cnt == PASS_PENULT) state_nx = FINAL;
            FINAL: if (in_beat && pix_cnt == PIX_LAST) state_nx = DRAIN;
            DRAIN: if (out_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; FINAL accepts whenever the single output register frees up this cycle
    always_comb begin
        in_ready = 1'b0;
        acc_we   = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                acc_we   = in_valid;
            end
            FINAL:   in_ready = !out_valid || out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Pass 0 ignores stale RAM contents, so no clear is needed between tiles
    always_comb begin
        acc_base = (pass_cnt == '0) ? '0 : acc_rd;
        acc_wr   = acc_base + ACC_WIDTH'(psum_in);
        sum_s    = acc_wr + bias;
`ifdef PSUM_ACC_QUANT_RELU_EN
        sum_q    = sum_s[ACC_WIDTH-1] ? '0 : sum_s;
`else
        sum_q    = sum_s;
`endif
        q_val    = OFM_WIDTH'(sat_round(64'(sum_q), SHIFT, OFM_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt   <= '0;
            pass_cnt  <= '0;
            out_valid <= 1'b0;
            ofm_out   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state == DRAIN) && out_hs;

            if (state == IDLE && start) begin
                pix_cnt  <= '0;
                pass_cnt <= '0;
            end else if (in_beat) begin
                if (pix_cnt == PIX_LAST) begin
                    pix_cnt  <= '0;
                    pass_cnt <= (pass_cnt == PASS_LAST) ? '0 : pass_cnt + PASS_W'(1);
                end else begin
                    pix_cnt  <= pix_cnt + PIX_W'(1);
                end
            end

            if (in_beat && state == FINAL) begin
                out_valid <= 1'b1;
                ofm_out   <= q_val;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_acc_quant.sv
// Bench for psum_acc_quant (DEPTH=4, NUM_PASS=2 and a NUM_PASS=1 instance); honours PSUM_ACC_QUANT_RELU_EN.
module tb_psum_acc_quant;

    localparam int D  = 4;
    localparam int P  = 2;
    localparam int SH = 4;
    localparam int OW = 8;
    localparam int AW = 24;
    localparam int PW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, in_valid, out_ready, sel;
    logic signed [AW-1:0] bias;
    logic signed [PW-1:0] psum_in;

    logic start0, start1, iv0, iv1;
    logic in_ready0, out_valid0, busy0, done0;
    logic in_ready1, out_valid1, busy1, done1;
    logic signed [OW-1:0] ofm0, ofm1;

    logic obs_in_ready, obs_out_valid, obs_busy, obs_done;
    logic signed [OW-1:0] obs_ofm;

    assign start0 = start && !sel;
    assign start1 = start && sel;
    assign iv0    = in_valid && !sel;
    assign iv1    = in_valid && sel;

    assign obs_in_ready  = sel ? in_ready1  : in_ready0;
    assign obs_out_valid = sel ? out_valid1 : out_valid0;
    assign obs_busy      = sel ? busy1      : busy0;
    assign obs_done      = sel ? done1      : done0;
    assign obs_ofm       = sel ? ofm1       : ofm0;

    psum_acc_quant #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW), .OFM_WIDTH(OW),
                     .DEPTH(D), .NUM_PASS(P), .SHIFT(SH)) u_dut (
        .clk(clk), .rst(rst), .start(start0), .bias(bias),
        .in_valid(iv0), .in_ready(in_ready0), .psum_in(psum_in),
        .out_valid(out_valid0), .out_ready(out_ready), .ofm_out(ofm0),
        .busy(busy0), .done(done0));

    psum_acc_quant #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW), .OFM_WIDTH(OW),
                     .DEPTH(D), .NUM_PASS(1), .SHIFT(SH)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .bias(bias),
        .in_valid(iv1), .in_ready(in_ready1), .psum_in(psum_in),
        .out_valid(out_valid1), .out_ready(out_ready), .ofm_out(ofm1),
        .busy(busy1), .done(done1));

    int tile_ps [P][D];
    int tile_bias;
    int got_q[$];
    int errors = 0;
    int checks = 0;

    // Reference: real-valued round-half-up division, optional clamp, saturation.
    function automatic int model_q(input longint s);
        longint dv, v, q, hi, lo;
        dv = longint'(1) << SH;
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
`ifdef PSUM_ACC_QUANT_RELU_EN
        if (s < 0) s = 0;
`endif
        v = s + dv / 2;
        q = (v >= 0) ? v / dv : -((-v + dv - 1) / dv);
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    function automatic int model_pix(input int np, input int d);
        longint s;
        s = longint'(tile_bias);
        for (int p = 0; p < np; p++) s += longint'(tile_ps[p][d]);
        return model_q(s);
    endfunction

    task automatic do_start();
        @(negedge clk);
        start    = 1'b1;
        bias     = AW'(tile_bias);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // One cycle: drive at negedge, observe handshakes before the next rising edge.
    task automatic step(input bit iv, input int ps, input bit ordy,
                        output bit ib, output bit oh, output int ofm, output bit dn);
        @(negedge clk);
        in_valid  = iv;
        psum_in   = PW'(ps);
        out_ready = ordy;
        #1;
        ib  = iv && obs_in_ready;
        oh  = obs_out_valid && ordy;
        ofm = int'(obs_ofm);
        dn  = obs_done;
    endtask

    task automatic run_tile(input int np, input int mode, output bit timed_out);
        int k, total, ofm;
        bit ib, oh, dn, fin;
        got_q.delete();
        k = 0; total = np * D; fin = 0;
        do_start();
        for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
            bit iv, ordy;
            int ps;
            iv   = (k < total) && (mode == 0 || $urandom_range(0, 3) != 0);
            ordy = (mode == 0) || ($urandom_range(0, 1) == 1);
            ps   = (k < total) ? tile_ps[k / D][k % D] : 0;
            step(iv, ps, ordy, ib, oh, ofm, dn);
            if (ib) k++;
            if (oh) got_q.push_back(ofm);
            if (dn) fin = 1;
        end
        in_valid  = 1'b0;
        timed_out = !fin;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
        bias = '0; psum_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy0 !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid0); end
        checks++; if (in_ready0 !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready0); end
        checks++; if (done0 !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done0); end
        checks++; if (ofm0 !== 8'sd0)      begin errors++; $display("FAIL reset_ofm got=%0d exp=0", ofm0); end
        checks++; if (busy1 !== 1'b0)      begin errors++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    endtask

    task automatic test_basic();
        bit to, ib, oh, dn;
        int ofm;
        tile_ps = '{'{100, 200, -50, 0}, '{60, 100, -100, 8}};
        tile_bias = 8;
        run_tile(P, 0, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b exp=0", to); end
        checks++; if (got_q.size() != D) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), D); end
        for (int d = 0; d < D && d < got_q.size(); d++) begin
            checks++;
            if (got_q[d] != model_pix(P, d)) begin
                errors++; $display("FAIL basic_pix%0d got=%0d exp=%0d", d, got_q[d], model_pix(P, d));
            end
        end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0] != 11) begin errors++; $display("FAIL basic_first got=%0d exp=11", got_q[0]); end
        end
        step(1'b0, 0, 1'b1, ib, oh, ofm, dn);
        checks++; if (dn !== 1'b0)       begin errors++; $display("FAIL done_one_cycle got=%b exp=0", dn); end
        checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%b exp=0", obs_busy); end
    endtask

    task automatic test_saturation();
        bit to;
        for (int sg = 0; sg < 2; sg++) begin
            for (int p = 0; p < P; p++)
                for (int d = 0; d < D; d++) tile_ps[p][d] = (sg == 0) ? 30000 : -30000;
            tile_bias = 0;
            run_tile(P, 0, to);
            checks++; if (to !== 1'b0 || got_q.size() != D) begin
                errors++; $display("FAIL sat%0d_count got=%0d exp=%0d timeout=%b", sg, got_q.size(), D, to);
            end
            for (int d = 0; d < D && d < got_q.size(); d++) begin
                checks++;
                if (got_q[d] != model_pix(P, d)) begin
                    errors++; $display("FAIL sat%0d_pix%0d got=%0d exp=%0d", sg, d, got_q[d], model_pix(P, d));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int k, stall, ofm, exp0;
        bit ib, oh, dn, fin, ordy;
        for (int p = 0; p < P; p++)
            for (int d = 0; d < D; d++) tile_ps[p][d] = int'($urandom_range(0, 4000)) - 2000;
        tile_bias = int'($urandom_range(0, 400)) - 200;
        exp0 = model_pix(P, 0);
        got_q.delete();
        k = 0; stall = 0; fin = 0;
        do_start();
        for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
            ordy = (stall >= 5);
            step(k < P * D, (k < P * D) ? tile_ps[k / D][k % D] : 0, ordy, ib, oh, ofm, dn);
            if (obs_out_valid && !ordy) begin
                stall++;
                checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, obs_in_ready); end
                checks++; if (ofm != exp0) begin errors++; $display("FAIL bp_hold cyc=%0d got=%0d exp=%0d", cyc, ofm, exp0); end
            end
            if (ib) k++;
            if (oh) got_q.push_back(ofm);
            if (dn) fin = 1;
        end
        in_valid = 1'b0;
        checks++; if (!fin || got_q.size() != D) begin
            errors++; $display("FAIL bp_count got=%0d exp=%0d done=%b", got_q.size(), D, fin);
        end
        for (int d = 0; d < D && d < got_q.size(); d++) begin
            checks++;
            if (got_q[d] != model_pix(P, d)) begin
                errors++; $display("FAIL bp_pix%0d got=%0d exp=%0d", d, got_q[d], model_pix(P, d));
            end
        end
    endtask

    task automatic test_random();
        bit to;
        for (int t = 0; t < 6; t++) begin
            for (int p = 0; p < P; p++)
                for (int d = 0; d < D; d++) tile_ps[p][d] = int'($urandom_range(0, 65535)) - 32768;
            tile_bias = int'($urandom_range(0, 2097152)) - 1048576;
            run_tile(P, 1, to);
            checks++; if (to !== 1'b0 || got_q.size() != D) begin
                errors++; $display("FAIL rand%0d_count got=%0d exp=%0d timeout=%b", t, got_q.size(), D, to);
            end
            for (int d = 0; d < D && d < got_q.size(); d++) begin
                checks++;
                if (got_q[d] != model_pix(P, d)) begin
                    errors++; $display("FAIL rand%0d_pix%0d got=%0d exp=%0d", t, d, got_q[d], model_pix(P, d));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        tile_ps = '{'{20000, -20000, 15000, 9000}, '{12000, -7000, 3000, 1000}};
        tile_bias = 500;
        run_tile(P, 0, to);
        for (int p = 0; p < P; p++)
            for (int d = 0; d < D; d++) tile_ps[p][d] = 1;
        tile_bias = 0;
        run_tile(P, 0, to);
        checks++; if (to !== 1'b0 || got_q.size() != D) begin
            errors++; $display("FAIL b2b_count got=%0d exp=%0d timeout=%b", got_q.size(), D, to);
        end
        for (int d = 0; d < D && d < got_q.size(); d++) begin
            checks++;
            if (got_q[d] != model_pix(P, d)) begin
                errors++; $display("FAIL b2b_pix%0d got=%0d exp=%0d", d, got_q[d], model_pix(P, d));
            end
        end
    endtask

    task automatic test_reset_mid_tile();
        bit to, ib, oh, dn;
        int ofm;
        tile_ps = '{'{100, 200, -50, 0}, '{60, 100, -100, 8}};
        tile_bias = 8;
        do_start();
        for (int k = 0; k < 2; k++) step(1'b1, tile_ps[0][k], 1'b1, ib, oh, ofm, dn);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; psum_in = PW'(tile_ps[0][2]);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (obs_busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got=%b exp=0", obs_busy); end
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", obs_out_valid); end
        checks++; if (obs_in_ready !== 1'b0)  begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", obs_in_ready); end
        checks++; if (obs_done !== 1'b0)      begin errors++; $display("FAIL midrst_done got=%b exp=0", obs_done); end
        run_tile(P, 0, to);
        checks++; if (to !== 1'b0 || got_q.size() != D) begin
            errors++; $display("FAIL midrst_count got=%0d exp=%0d timeout=%b", got_q.size(), D, to);
        end
        for (int d = 0; d < D && d < got_q.size(); d++) begin
            checks++;
            if (got_q[d] != model_pix(P, d)) begin
                errors++; $display("FAIL midrst_pix%0d got=%0d exp=%0d", d, got_q[d], model_pix(P, d));
            end
        end
    endtask

    task automatic test_single_pass();
        bit to;
        int sp[D] = '{16, 32, -16, 0};
        sel = 1'b1;
        for (int t = 0; t < 3; t++) begin
            for (int d = 0; d < D; d++)
                tile_ps[0][d] = (t == 0) ? sp[d] : int'($urandom_range(0, 65535)) - 32768;
            tile_bias = (t == 0) ? 0 : int'($urandom_range(0, 2000)) - 1000;
            run_tile(1, (t == 0) ? 0 : 1, to);
            checks++; if (to !== 1'b0 || got_q.size() != D) begin
                errors++; $display("FAIL np1_t%0d_count got=%0d exp=%0d timeout=%b", t, got_q.size(), D, to);
            end
            for (int d = 0; d < D && d < got_q.size(); d++) begin
                checks++;
                if (got_q[d] != model_pix(1, d)) begin
                    errors++; $display("FAIL np1_t%0d_pix%0d got=%0d exp=%0d", t, d, got_q[d], model_pix(1, d));
                end
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid_tile();
        test_single_pass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/psum_acc_quant.md
Name: psum_acc_quant

Overview:
- Downstream stage of one PE column.
- Takes the column's 16-bit partial sums, one per output pixel, and accumulates them across NUM_PASS input-channel passes in a DEPTH-entry local buffer.
- On the final pass it adds bias, optionally applies ReLU, then round-shifts and saturates to the 8-bit OFM format.
- Results stream out under valid/ready backpressure toward the OFM buffer.

Parameters:
- PSUM_WIDTH, 16, width of incoming PE partial sum (signed)
- ACC_WIDTH, 24, internal accumulator width (signed); wraps two's complement, sized so no overflow occurs
- OFM_WIDTH, 8, output activation width (signed)
- DEPTH, 16, output pixels per tile (accumulator entries), ≥2
- NUM_PASS, 4, channel passes per tile, ≥1
- SHIFT, 4, requantization right shift, ≥1

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a tile; ignored unless IDLE
- bias  in  ACC_WIDTH  signed bias; held stable by the controller from start until done
- in_valid  in  1  psum_in valid
- in_ready  out  1  block can accept psum_in
- psum_in  in  PSUM_WIDTH  signed partial sum from PE column
- out_valid  out  1  ofm_out valid
- out_ready  in  1  downstream accepts ofm_out
- ofm_out  out  OFM_WIDTH  signed quantized activation
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse when tile's last output is accepted

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Accumulator RAM contents are don't-care because pass 0 overwrites.
- Reset mid-tile aborts immediately; no done pulse.
- Clock and reset: one clock, synchronous active-high reset.
- Beat definition: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Counters: pix_cnt 0..DEPTH-1, pass_cnt 0..NUM_PASS-1. Each beat increments pix_cnt. On wrap DEPTH-1→0, pass_cnt increments.
- FSM states:
  - IDLE: in_ready=0. start → ACCUM if NUM_PASS>1, else FINAL.
  - ACCUM: in_ready=1. Each beat writes acc[pix] = (pass_cnt==0 ? 0 : acc[pix]) + sext(psum_in). A beat at pix=DEPTH-1 with pass_cnt==NUM_PASS-2 → FINAL.
  - FINAL: in_ready = !out_valid || out_ready (single output register). Each beat computes s = acc[pix] + sext(psum_in) + bias. For NUM_PASS==1, acc term is 0. The result is loaded into ofm_out with out_valid=1 the next cycle (latency 1). A beat at pix=DEPTH-1 → DRAIN.
  - DRAIN: in_ready=0. On output handshake: out_valid→0, done=1 for 1 cycle, → IDLE.
- Quantize, in order:
  1. Optional ReLU (see below).
  2. r = (s + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, round half up.
  3. Saturate to [-2^(OFM_WIDTH-1), 2^(OFM_WIDTH-1)-1].
- out_valid stays high and ofm_out stays stable until out_ready. A simultaneous accept and new beat in FINAL loads the new value with no bubble.
- start during busy: ignored. in_valid in IDLE/DRAIN: not accepted.

Optional Feature:
- Macro: PSUM_ACC_QUANT_RELU_EN.
- Defined: s<0 is clamped to 0 before the shift, so output range is [0, 2^(OFM_WIDTH-1)-1].
- Undefined: no clamp; signed output.

Decomposition:
- Shared package cnn_pkg holds:
  - ACC_WIDTH and OFM_WIDTH defaults
  - the FSM state enum {IDLE, ACCUM, FINAL, DRAIN}
  - a sat_round function (round, shift, saturate)
- One sub-module: psum_acc_ram, a DEPTH×ACC_WIDTH register-file accumulator with 1 read / 1 write port in the same cycle.

Test Plan (DEPTH=4, NUM_PASS=2, SHIFT=4):
- Basic, ReLU off: bias=8; pass0 psums 100,200,-50,0; pass1 60,100,-100,8 → ofm 11,19,-9,1, then done pulse. With ReLU on → 11,19,0,1.
- Saturation: bias=0; both passes 30000 each pixel → 127 ×4. Both passes -30000 → -128 (ReLU off) or 0 (ReLU on).
- Backpressure: hold out_ready=0 for 5 cycles during FINAL → in_ready=0 after first output, ofm_out stable. Release → remaining outputs in order, no loss or duplication.
- Back-to-back tiles: second start 1 cycle after done, all psums 1, bias=0 → outputs 0 (2+8>>4=0). Confirms pass-0 overwrite: no carry-over from the prior tile's acc.
- Reset mid-tile: assert rst in ACCUM at pix 2 → next cycle busy=0, out_valid=0, in_ready=0. A fresh tile then yields correct values as in the first test.
- NUM_PASS=1 build: start → FINAL directly; psums 16,32,-16,0, bias=0 → 1,2,-1,0 (ReLU off).
